fetch_prefetch_unit: RTL and testbench

- Upstream feeder for the control unit: owns the program counter, issues reads to the synchronous program ROM and buffers returned bytes in a small prefetch queue.
- Presents the head byte to the control unit as a valid/take stream. `byte_take` is the control unit's per-byte consume strobe, formerly `pc_inc`.
- Supports redirect (jump), which flushes the queue and any in-flight read.

---
 rtl/fetch_prefetch_unit.sv | 144 ++++++++++++++
 tb/tb_fetch_prefetch_unit.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/fetch_prefetch_unit.sv
// fetch_prefetch_unit
// Owns the program counter and issues reads to a synchronous program ROM
// whose data returns one cycle after the request. Returned bytes are
// buffered in a small circular prefetch queue. The head byte is presented
// to the control unit as a valid/take stream. A jump flushes the queue
// together with any read still in flight and restarts fetch at the target.
module fetch_prefetch_unit #(
    parameter int                 ADDR_W     = 8,
    parameter int                 DEPTH      = 4,
    parameter logic [ADDR_W-1:0]  RESET_ADDR = '0
) (
    input  logic              clk,
    input  logic              rst,
    output logic              rom_en,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [7:0]        rom_data,
    output logic [7:0]        byte_out,
    output logic              byte_valid,
    output logic [ADDR_W-1:0] byte_pc,
    input  logic              byte_take,
    input  logic              jump_en,
    input  logic [ADDR_W-1:0] jump_addr
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    // Fetch side: next address to request, plus the address of the read in flight
    logic [ADDR_W-1:0] r_fetch_pc;
    logic [ADDR_W-1:0] r_req_pc;
    logic              r_inflight;

    // Queue bookkeeping
    logic [PTR_W-1:0]  r_head;
    logic [PTR_W-1:0]  r_tail;
    logic [CNT_W-1:0]  r_count;

    // Queue storage: instruction byte and the ROM address it came from
    logic [7:0]        r_data_mem [DEPTH];
    logic [ADDR_W-1:0] r_pc_mem   [DEPTH];

    // Registered head view so the outputs hold their value while the queue is empty
    logic [7:0]        r_byte_out;
    logic [ADDR_W-1:0] r_byte_pc;

    // Combinational control
    logic [CNT_W:0]    w_occupancy;
    logic              w_rom_en;
    logic              w_capture;
    logic              w_pop;
    logic [PTR_W-1:0]  w_head_next;
    logic [CNT_W-1:0]  w_count_after_pop;
    logic [CNT_W-1:0]  w_count_next;
    logic [7:0]        w_head_data_next;
    logic [ADDR_W-1:0] w_head_pc_next;

    // The in-flight read reserves a queue slot, so a capture can never overflow.
    // A pop in the same cycle is deliberately not credited.
    assign w_occupancy       = {1'b0, r_count} + (CNT_W + 1)'(r_inflight);
    assign w_rom_en          = !rst && !jump_en && (w_occupancy < (CNT_W + 1)'(DEPTH));
    assign w_capture         = r_inflight && !jump_en;
    assign w_pop             = byte_take && (r_count != '0) && !jump_en;
    assign w_head_next       = r_head + PTR_W'(w_pop);
    assign w_count_after_pop = r_count - CNT_W'(w_pop);
    assign w_count_next      = w_count_after_pop + CNT_W'(w_capture);

    // Select the byte that will sit at the head after this edge
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        w_head_data_next = r_byte_out;
        w_head_pc_next   = r_byte_pc;
        if (w_count_next != '0) begin
            if (w_count_after_pop == '0) begin
                // Queue drains to empty this edge, so the byte being captured becomes the head
                w_head_data_next = rom_data;
                w_head_pc_next   = r_req_pc;
            end else begin
                w_head_data_next = r_data_mem[w_head_next];
                w_head_pc_next   = r_pc_mem[w_head_next];
            end
        end
    end

    // Program counter and in-flight tracking
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
        if (rst) begin
            r_fetch_pc <= RESET_ADDR;
            r_req_pc   <= RESET_ADDR;
            r_inflight <= 1'b0;
        end else if (jump_en) begin
            r_fetch_pc <= jump_addr;
            r_inflight <= 1'b0;
        end else begin
            r_inflight <= w_rom_en;
            if (w_rom_en) begin
                r_req_pc   <= r_fetch_pc;
                r_fetch_pc <= r_fetch_pc + 1'b1;
            end
        end
    end

    // Queue pointers and occupancy; reset and jump both flush
    always_ff @(posedge clk) begin
        if (rst || jump_en) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_capture) begin
                r_tail <= r_tail + 1'b1;
            end
            r_head  <= w_head_next;
            r_count <= w_count_next;
        end
    end

    // Queue storage write on capture
    always_ff @(posedge clk) begin
        // NOTE: the storage array is not reset; entries are only read once count marks them valid.
        if (!rst && w_capture) begin
            r_data_mem[r_tail] <= rom_data;
            r_pc_mem[r_tail]   <= r_req_pc;
        end
    end

    // Head byte and its address, held while the queue is empty
    always_ff @(posedge clk) begin
        if (rst) begin
            r_byte_out <= 8'h00;
            r_byte_pc  <= RESET_ADDR;
        end else if (!jump_en) begin
            r_byte_out <= w_head_data_next;
            r_byte_pc  <= w_head_pc_next;
        end
    end

    assign rom_en     = w_rom_en;
    assign rom_addr   = r_fetch_pc;
    assign byte_valid = (r_count != '0);
    assign byte_out   = r_byte_out;
    assign byte_pc    = r_byte_pc;

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// tb_fetch_prefetch_unit
// Two instances share a ROM image: dut0 (reset address 0x00) receives the
// directed and random stream; dut1 (reset address 0xFE) consumes every cycle
// to exercise PC wrap and sustained throughput.
module tb_fetch_prefetch_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic       byte_take;
    logic       jump_en;
    logic [7:0] jump_addr;

    logic       rom_en0, byte_valid0;
    logic [7:0] rom_addr0, rom_data0, byte_out0, byte_pc0;
    logic       rom_en1, byte_valid1;
    logic [7:0] rom_addr1, rom_data1, byte_out1, byte_pc1;

    logic [7:0] rom [256];

    int total = 0;
    int bad   = 0;

    // Reference model state (dut0): ordered stream of sequential addresses
    int         cyc = 0;
    int         pending [$];   // issue cycle of each request not yet visible
    int         ready   = 0;   // bytes visible in the queue
    logic [7:0] exp_fetch = 8'h00;
    logic [7:0] exp_head  = 8'h00;
    bit         just_reset = 1'b1;
    bit         exp_en;

    // Reference model state (dut1)
    logic [7:0] exp_pc1 = 8'hFE;
    int         idle1 = 0;

    always #5 clk = ~clk;

    fetch_prefetch_unit #(.ADDR_W(8), .DEPTH(4), .RESET_ADDR(8'h00)) dut0 (
        .clk(clk), .rst(rst), .rom_en(rom_en0), .rom_addr(rom_addr0),
        .rom_data(rom_data0), .byte_out(byte_out0), .byte_valid(byte_valid0),
        .byte_pc(byte_pc0), .byte_take(byte_take), .jump_en(jump_en),
        .jump_addr(jump_addr)
    );

    fetch_prefetch_unit #(.ADDR_W(8), .DEPTH(4), .RESET_ADDR(8'hFE)) dut1 (
        .clk(clk), .rst(rst), .rom_en(rom_en1), .rom_addr(rom_addr1),
        .rom_data(rom_data1), .byte_out(byte_out1), .byte_valid(byte_valid1),
        .byte_pc(byte_pc1), .byte_take(1'b1), .jump_en(1'b0),
        .jump_addr(8'h00)
    );

    // Synchronous ROMs: data valid the cycle after the request
    always @(posedge clk) begin
        if (rom_en0) rom_data0 <= rom[rom_addr0];
        if (rom_en1) rom_data1 <= rom[rom_addr1];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs, check at the falling edge, advance model across the rising edge
    task automatic step(input bit r, input bit tk, input bit j, input logic [7:0] ja);
        rst       = r;
        byte_take = tk;
        jump_en   = j;
        jump_addr = ja;
        @(negedge clk);

        // A request issued in cycle N is visible from cycle N+2
        while (pending.size() > 0 && pending[0] <= cyc - 2) begin
            void'(pending.pop_front());
            ready++;
        end
        exp_en = !r && !j && ((pending.size() + ready) < 4);

        check("rom_en", rom_en0, exp_en);
        if (exp_en) check("rom_addr", rom_addr0, exp_fetch);
        check("byte_valid", byte_valid0, ready > 0);
        if (ready > 0) begin
            check("byte_pc", byte_pc0, exp_head);
            check("byte_out", byte_out0, rom[exp_head]);
        end
        if (just_reset) begin
            check("rst_byte_out", byte_out0, 8'h00);
            check("rst_byte_pc", byte_pc0, 8'h00);
            check("rst_byte_pc1", byte_pc1, 8'hFE);
        end

        check("byte_valid1", byte_valid1, idle1 >= 2);
        if (byte_valid1) begin
            check("byte_pc1", byte_pc1, exp_pc1);
            check("byte_out1", byte_out1, rom[exp_pc1]);
        end

        if (r) begin
            pending.delete();
            ready      = 0;
            exp_fetch  = 8'h00;
            exp_head   = 8'h00;
            just_reset = 1'b1;
            exp_pc1    = 8'hFE;
            idle1      = 0;
        end else begin
            just_reset = 1'b0;
            idle1++;
            if (byte_valid1) exp_pc1++;
            if (j) begin
                pending.delete();
                ready     = 0;
                exp_fetch = ja;
                exp_head  = ja;
            end else begin
                if (exp_en) begin
                    pending.push_back(cyc);
                    exp_fetch++;
                end
                if (tk && ready > 0) begin
                    ready--;
                    exp_head++;
                end
            end
        end

        @(posedge clk);
        #1;
        cyc++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 256; i++) begin
            rom[i] = (i < 32) ? 8'(8'h10 + i) : 8'($urandom);
        end
        rst = 1'b1; byte_take = 1'b0; jump_en = 1'b0; jump_addr = 8'h00;
        @(posedge clk);
        #1;

        // Reset state, then fill the queue with nobody taking
        step(1, 0, 0, 8'h00);
        step(1, 0, 0, 8'h00);
        for (int i = 0; i < 8; i++) step(0, 0, 0, 8'h00);

        // Drain a full queue while taking every cycle
        for (int i = 0; i < 6; i++) step(0, 1, 0, 8'h00);

        // Three queued bytes plus one in flight, then jump with a simultaneous take
        step(1, 0, 0, 8'h00);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 8'h00);
        step(0, 1, 1, 8'h40);
        for (int i = 0; i < 6; i++) step(0, 1, 0, 8'h00);

        // Take every other cycle
        for (int i = 0; i < 20; i++) step(0, bit'(i % 2), 0, 8'h00);

        // Reset mid-stream with a read in flight
        for (int i = 0; i < 3; i++) step(0, 1, 0, 8'h00);
        step(1, 1, 0, 8'h00);
        for (int i = 0; i < 6; i++) step(0, 1, 0, 8'h00);

        // Random traffic: takes, jumps to random targets, occasional resets
        for (int i = 0; i < 400; i++) begin
            step(bit'($urandom_range(0, 63) == 0),
                 bit'($urandom_range(0, 1)),
                 bit'($urandom_range(0, 15) == 0),
                 8'($urandom));
        end
        for (int i = 0; i < 8; i++) step(0, 1, 0, 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
